// File: rtl/lm32_trace_buffer.sv
// Retired-instruction trace buffer: tracks instruction_d down to W, records
// {pc, trig, disc, inst} per retire into a circular buffer, drains via valid/ready.
module lm32_trace_buffer #(
  parameter int DEPTH     = 64,
  parameter int PC_WIDTH  = 30,
  parameter int POST_TRIG = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          stall_x,
  input  logic                          stall_m,
  input  logic                          valid_w,
  input  logic                          kill_w,
  input  logic [31:0]                   instruction_d,
  input  logic [PC_WIDTH-1:0]           pc_w,
  input  logic                          arm_i,
  input  logic                          abort_i,
  input  logic                          mode_i,
  input  logic                          trig_en_i,
  input  logic [PC_WIDTH-1:0]           trig_pc_i,
  input  logic                          rd_ready_i,
  output logic                          rd_valid_o,
  output logic [63:0]                   rd_data_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [1:0]                    state_o,
  output logic                          wrapped_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_POST = 2'b10, S_DONE = 2'b11} state_e;

  state_e               state_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q, post_cnt_q;
  logic [CW-1:0]        count_q;
  logic                 wrapped_q;
  logic [PC_WIDTH-1:0]  last_pc_q;
  logic                 last_valid_q;
  logic [31:0]          inst_x_q, inst_m_q, inst_w_q;
  logic [63:0]          mem [DEPTH];

  logic retire, capturing, disc, rec, trig, pop;
  logic [63:0] entry_d;

  // Shadow of the core's X/M/W instruction registers, honouring its stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inst_x_q <= '0;
      inst_m_q <= '0;
      inst_w_q <= '0;
    end else begin
      if (!stall_x) inst_x_q <= instruction_d;
      if (!stall_m) inst_m_q <= inst_x_q;
      inst_w_q <= inst_m_q;
    end
  end

  assign retire    = valid_w & ~kill_w;
  assign capturing = (state_q == S_ARMED) | (state_q == S_POST);
  assign disc      = ~last_valid_q | (pc_w != last_pc_q + PC_WIDTH'(1));
  assign rec       = retire & capturing & (~mode_i | disc) & ~abort_i;
  assign trig      = rec & (state_q == S_ARMED) & (trig_en_i ? (pc_w == trig_pc_i) : 1'b1);
  assign pop       = (state_q == S_DONE) & (count_q != '0) & rd_ready_i & ~abort_i;
  assign entry_d   = {30'(pc_w), trig, disc, inst_w_q};

  // Storage carries no reset; count_q alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (rec) mem[wr_ptr_q] <= entry_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      post_cnt_q   <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            state_q      <= S_ARMED;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wrapped_q    <= 1'b0;
            last_valid_q <= 1'b0;
          end
        end
        S_ARMED, S_POST: begin
          if (retire) begin
            last_pc_q    <= pc_w;
            last_valid_q <= 1'b1;
          end
          if (rec) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            // Full buffer: the oldest entry is overwritten, so the read side moves too.
            if (count_q == FULL) begin
              rd_ptr_q  <= rd_ptr_q + AW'(1);
              wrapped_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
          if (state_q == S_ARMED) begin
            if (trig) begin
              post_cnt_q <= POST_INIT;
              state_q    <= (POST_TRIG == 0) ? S_DONE : S_POST;
            end
          end else if (rec) begin
            post_cnt_q <= post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q - CW'(1);
            if (count_q == CW'(1)) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_valid_o = (state_q == S_DONE) & (count_q != '0);
  assign rd_data_o  = mem[rd_ptr_q];
  assign count_o    = count_q;
  assign state_o    = state_q;
  assign wrapped_o  = wrapped_q;
endmodule
